// File: rtl/reflet_mem_access.sv
// Load/store unit between the Reflet core and a synchronous single-port RAM.
// Word-crossing accesses are split into two word operations; partial stores use read-modify-write.
module reflet_mem_access #(
  parameter int wordsize         = 16,
  parameter int read_latency     = 1,
  parameter int allow_misaligned = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [$clog2(wordsize/8):0]    req_size,
  input  logic [wordsize-1:0]            req_addr,
  input  logic [wordsize-1:0]            req_wdata,
  output logic                           rsp_valid,
  output logic [wordsize-1:0]            rsp_rdata,
  output logic                           rsp_error,
  output logic [wordsize-1:0]            ram_addr,
  output logic [wordsize-1:0]            ram_data_out,
  input  logic [wordsize-1:0]            ram_data_in,
  output logic                           ram_write_en
);
  localparam int WB     = wordsize / 8;
  localparam int LOG_WB = $clog2(WB);
  localparam int SW     = LOG_WB + 1;
  localparam int CW     = $clog2(read_latency + 1);

  localparam logic [wordsize-1:0] OFF_MASK = wordsize'(WB - 1);
  localparam logic [wordsize-1:0] WB_A     = wordsize'(WB);
  localparam logic [wordsize-1:0] ONE_A    = wordsize'(1);
  localparam logic [wordsize:0]   WB_W     = (wordsize + 1)'(WB);
  localparam logic [wordsize:0]   ONE_W    = (wordsize + 1)'(1);
  localparam logic [2*WB-1:0]     ONE_B    = (2 * WB)'(1);
  localparam logic [SW-1:0]       MAX_SIZE = SW'(LOG_WB);
  localparam logic [CW-1:0]       CNT_LAST = CW'(read_latency);

  typedef enum logic [2:0] {IDLE, RD_LO, WR_LO, RD_HI, WR_HI, RESP, ERR} state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 write_reg;
  logic [SW-1:0]        size_reg;
  logic [wordsize-1:0]  addr_reg, wdata_reg, lo_reg, hi_reg;
  logic                 capture_lo, capture_hi;

  // Decode of the incoming request, used only on the acceptance edge
  logic [wordsize:0]    off_in, nb_in;
  logic                 err_in, full_in;
  assign off_in  = {1'b0, req_addr & OFF_MASK};
  assign nb_in   = ONE_W << req_size;
  assign err_in  = (req_size > MAX_SIZE) ||
                   ((allow_misaligned == 0) && ((({1'b0, req_addr}) & (nb_in - ONE_W)) != '0));
  assign full_in = (off_in == '0) && (nb_in == WB_W);

  // Decode of the latched request
  logic [wordsize:0]     off_r, nb_r;
  logic                  split_r;
  logic [wordsize-1:0]   base_r, base_hi;
  logic [2*wordsize-1:0] wsh;
  logic [2*WB-1:0]       bmask;
  logic [wordsize-1:0]   rshift, dmask, rdata_w, merged_lo, merged_hi;

  assign off_r   = {1'b0, addr_reg & OFF_MASK};
  assign nb_r    = ONE_W << size_reg;
  assign split_r = (off_r + nb_r) > WB_W;
  assign base_r  = addr_reg & ~OFF_MASK;
  assign base_hi = base_r + WB_A;
  assign wsh     = {{wordsize{1'b0}}, wdata_reg} << {off_r, 3'b000};
  assign bmask   = ((ONE_B << nb_r) - ONE_B) << off_r;
  assign rshift  = wordsize'({hi_reg, lo_reg} >> {off_r, 3'b000});
  // A full-word mask comes out as all ones through the wrap of 0 - 1
  assign dmask   = (ONE_A << {nb_r, 3'b000}) - ONE_A;
  assign rdata_w = rshift & dmask;

  genvar gi;
  generate
    for (gi = 0; gi < WB; gi++) begin : g_merge
      assign merged_lo[8*gi +: 8] = bmask[gi]      ? wsh[8*gi +: 8]            : lo_reg[8*gi +: 8];
      assign merged_hi[8*gi +: 8] = bmask[WB + gi] ? wsh[wordsize + 8*gi +: 8] : hi_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    rsp_error    = 1'b0;
    rsp_rdata    = '0;
    ram_addr     = '0;
    ram_data_out = '0;
    ram_write_en = 1'b0;
    capture_lo   = 1'b0;
    capture_hi   = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        cnt_next  = '0;
        if (req_valid) begin
          if (err_in)                    state_next = ERR;
          else if (req_write && full_in) state_next = WR_LO;
          else                           state_next = RD_LO;
        end
      end
      RD_LO: begin
        ram_addr = base_r;
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          capture_lo = 1'b1;
          state_next = write_reg ? WR_LO : (split_r ? RD_HI : RESP);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WR_LO: begin
        ram_addr     = base_r;
        ram_data_out = merged_lo;
        ram_write_en = enable;
        state_next   = split_r ? RD_HI : RESP;
      end
      RD_HI: begin
        ram_addr = base_hi;
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          capture_hi = 1'b1;
          state_next = write_reg ? WR_HI : RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      WR_HI: begin
        ram_addr     = base_hi;
        ram_data_out = merged_hi;
        ram_write_en = enable;
        state_next   = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = write_reg ? '0 : rdata_w;
        state_next = IDLE;
      end
      ERR: begin
        rsp_valid  = 1'b1;
        rsp_error  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
    end else if (enable) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req_valid) begin
        write_reg <= req_write;
        size_reg  <= req_size;
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
      end
      if (capture_lo) lo_reg <= ram_data_in;
      if (capture_hi) hi_reg <= ram_data_in;
    end
  end
endmodule

// File: tb/tb_reflet_mem_access.sv
// Directed bench for reflet_mem_access: latency, merge data, splits, errors, enable and reset.
module tb_reflet_mem_access;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [15:0] req_addr = 16'h0, req_wdata = 16'h0;
  logic        rdy0, rv0, err0, rwe0, rdy1, rv1, err1, rwe1;
  logic [15:0] rdata0, raddr0, rdo0, rdata1, raddr1, rdo1;
  logic [15:0] ram_in0;
  logic [15:0] ram_in1 = 16'h7788;

  logic [15:0] mem [0:32767];
  int          wr_count = 0;
  logic [15:0] addr_q[$];
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  reflet_mem_access #(.wordsize(16), .read_latency(1), .allow_misaligned(1)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(valid0), .req_ready(rdy0),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_error(err0), .ram_addr(raddr0),
    .ram_data_out(rdo0), .ram_data_in(ram_in0), .ram_write_en(rwe0));

  reflet_mem_access #(.wordsize(16), .read_latency(1), .allow_misaligned(0)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .req_valid(valid1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_error(err1), .ram_addr(raddr1),
    .ram_data_out(rdo1), .ram_data_in(ram_in1), .ram_write_en(rwe1));

  // Synchronous RAM model with one cycle read latency
  always @(posedge clk) begin
    ram_in0 <= mem[raddr0[15:1]];
    if (rwe0) begin
      mem[raddr0[15:1]] <= rdo0;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit sel, input logic wr, input logic [1:0] sz,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output int lat, output logic [15:0] rd, output logic er, output int nwr);
    int g;
    int w0;
    logic [15:0] a;
    g = 0;
    @(negedge clk);
    while (!(rdy0 && rdy1) && g < 50) begin
      @(negedge clk);
      g++;
    end
    w0 = wr_count;
    addr_q.delete();
    req_write = wr; req_size = sz; req_addr = addr; req_wdata = wd;
    valid0 = !sel; valid1 = sel;
    @(posedge clk);
    #1;
    valid0 = 1'b0; valid1 = 1'b0;
    lat = -1; rd = 16'hxxxx; er = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sel ? rv1 : rv0) begin
        lat = n;
        rd  = sel ? rdata1 : rdata0;
        er  = sel ? err1 : err0;
        break;
      end
      a = sel ? raddr1 : raddr0;
      if (addr_q.size() == 0 || addr_q[addr_q.size()-1] != a) addr_q.push_back(a);
    end
    nwr = wr_count - w0;
    $display("req dut%0d wr=%0b size=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b writes=%0d",
             sel, wr, sz, addr, wd, lat, rd, er, nwr);
  endtask

  initial begin
    int lat, nwr, seen;
    logic [15:0] rd;
    logic er;
    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_value("rst_ready", rdy0, 1);
    check_value("rst_valid", rv0, 0);
    check_value("rst_rdata", rdata0, 0);
    check_value("rst_addr", raddr0, 0);
    check_value("rst_we", rwe0, 0);

    // Aligned load
    mem[16'h0010 >> 1] = 16'hBBAA;
    mem[16'h0012 >> 1] = 16'hDDCC;
    do_req(0, 0, 2'd1, 16'h0010, 16'h0, lat, rd, er, nwr);
    check_value("ld_al_lat", lat, 3);
    check_value("ld_al_data", rd, 16'hBBAA);
    check_value("ld_al_err", er, 0);
    check_value("ld_al_nwr", nwr, 0);

    // Split load
    do_req(0, 0, 2'd1, 16'h0011, 16'h0, lat, rd, er, nwr);
    check_value("ld_sp_lat", lat, 5);
    check_value("ld_sp_data", rd, 16'hCCBB);
    check_value("ld_sp_naddr", addr_q.size(), 2);
    if (addr_q.size() == 2) begin
      check_value("ld_sp_addr0", addr_q[0], 16'h0010);
      check_value("ld_sp_addr1", addr_q[1], 16'h0012);
    end

    // Byte store into the upper byte of a word
    do_req(0, 1, 2'd0, 16'h0013, 16'h005A, lat, rd, er, nwr);
    check_value("st_b_lat", lat, 4);
    check_value("st_b_nwr", nwr, 1);
    check_value("st_b_mem", mem[16'h0012 >> 1], 16'h5ACC);
    check_value("st_b_rdata", rd, 0);

    // Split store
    mem[16'h0012 >> 1] = 16'hDDCC;
    do_req(0, 1, 2'd1, 16'h0011, 16'h1234, lat, rd, er, nwr);
    check_value("st_sp_lat", lat, 7);
    check_value("st_sp_nwr", nwr, 2);
    check_value("st_sp_lo", mem[16'h0010 >> 1], 16'h34AA);
    check_value("st_sp_hi", mem[16'h0012 >> 1], 16'hDD12);

    // Byte load at odd offset, zero-extended
    do_req(0, 0, 2'd0, 16'h0011, 16'h0, lat, rd, er, nwr);
    check_value("ld_b_lat", lat, 3);
    check_value("ld_b_data", rd, 16'h0034);

    // Full-word aligned store skips the read
    do_req(0, 1, 2'd1, 16'h0030, 16'hA55A, lat, rd, er, nwr);
    check_value("st_fw_lat", lat, 2);
    check_value("st_fw_mem", mem[16'h0030 >> 1], 16'hA55A);
    check_value("st_fw_naddr", addr_q.size(), 1);

    // Oversized access is an error regardless of alignment mode
    do_req(0, 0, 2'd2, 16'h0010, 16'h0, lat, rd, er, nwr);
    check_value("err_sz_lat", lat, 1);
    check_value("err_sz_err", er, 1);
    check_value("err_sz_rdata", rd, 0);
    check_value("err_sz_noram", addr_q.size(), 0);

    // Strict alignment unit
    do_req(1, 0, 2'd1, 16'h0011, 16'h0, lat, rd, er, nwr);
    check_value("err_mis_lat", lat, 1);
    check_value("err_mis_err", er, 1);
    do_req(1, 0, 2'd0, 16'h0011, 16'h0, lat, rd, er, nwr);
    check_value("strict_b_lat", lat, 3);
    check_value("strict_b_err", er, 0);
    check_value("strict_b_data", rd, 16'h0077);

    // Clock enable freezes a full-word store in WR_LO
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd1; req_addr = 16'h0020; req_wdata = 16'hCAFE;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0; enable = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rwe0 || rv0) seen++;
    end
    check_value("en_hold", seen, 0);
    check_value("en_hold_mem", mem[16'h0020 >> 1], 16'h0000);
    enable = 1'b1;
    #1;
    check_value("en_write", rwe0, 1);
    @(negedge clk);
    check_value("en_resp", rv0, 1);
    check_value("en_mem", mem[16'h0020 >> 1], 16'hCAFE);
    $display("req dut0 store 0020 with enable gap -> mem=%h", mem[16'h0020 >> 1]);

    // Wrapping split store interrupted by reset during RD_HI
    mem[16'hFFFE >> 1] = 16'h1122;
    mem[0] = 16'h3344;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd1; req_addr = 16'hFFFF; req_wdata = 16'hBEEF;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    repeat (4) @(negedge clk);
    check_value("wrap_addr", raddr0, 16'h0000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("rst_mid_ready", rdy0, 1);
    check_value("rst_mid_we", rwe0, 0);
    @(negedge clk);
    check_value("rst_mid_hi", mem[0], 16'h3344);
    check_value("rst_mid_lo", mem[16'hFFFE >> 1], 16'hEF22);
    $display("req dut0 store FFFF reset in RD_HI -> mem[FFFE]=%h mem[0000]=%h",
             mem[16'hFFFE >> 1], mem[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
